gpr_wb_arbiter: RTL and testbench

Arbiter and one-entry holding buffer that shares the single GPR write port of the decode stage's register file between two requesters. The pipeline's Write-back stage writes every cycle it has a result; the long-latency execution unit (divider/multiplier) delivers results asynchronously to the pipeline. The block sits between those two sources and the register file write port. It exposes pending-write status to the hazard logic.

---
 rtl/gpr_wb_arbiter_pkg.sv | 13 +
 rtl/gpr_wb_arbiter_if.sv | 31 +++
 rtl/gpr_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared widths and FSM state encoding for the GPR write-port arbiter.
package gpr_wb_arbiter_pkg;

    localparam int GPR_AW = 5;
    localparam int XLEN   = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Bundle of Write-back, long-latency and register-file port signals around the arbiter.
interface gpr_wb_arbiter_if;
    import gpr_wb_arbiter_pkg::*;

    logic              W_gpr_wen;
    logic [GPR_AW-1:0] W_rd_addr;
    logic [XLEN-1:0]   W_rd;
    logic              W_stall;
    logic              L_valid;
    logic              L_ready;
    logic [GPR_AW-1:0] L_rd_addr;
    logic [XLEN-1:0]   L_rd;
    logic              gpr_wen;
    logic [GPR_AW-1:0] gpr_waddr;
    logic [XLEN-1:0]   gpr_wdata;
    logic              pend_valid;
    logic [GPR_AW-1:0] pend_rd_addr;

    // Pipeline / execution-unit side
    modport master (
        output W_gpr_wen, W_rd_addr, W_rd, L_valid, L_rd_addr, L_rd,
        input  W_stall, L_ready, gpr_wen, gpr_waddr, gpr_wdata, pend_valid, pend_rd_addr
    );

    // Arbiter side
    modport slave (
        input  W_gpr_wen, W_rd_addr, W_rd, L_valid, L_rd_addr, L_rd,
        output W_stall, L_ready, gpr_wen, gpr_waddr, gpr_wdata, pend_valid, pend_rd_addr
    );

endinterface

// File: rtl/gpr_wb_arbiter.sv
// Shares the GPR write port between Write-back and a one-entry long-latency holding buffer.
// Starvation guard (counter + FORCE state + W_stall) is built only with GPR_WB_STARVE_GUARD_EN.
//
//   state | meaning
//   EMPTY | no held result, L_ready high
//   HELD  | result held, waits for a cycle without a Write-back write
//   FORCE | result held and starved STARVE_MAX times; it takes the port, W stalls
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    gpr_wb_arbiter_if.slave bus
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [GPR_AW-1:0] pend_addr;
    logic [XLEN-1:0]   pend_data;
    logic              pend_valid;
    logic              w_req;
    logic              load;
    logic              wen_c;
    logic              stall_c;
    logic [GPR_AW-1:0] waddr_c;
    logic [XLEN-1:0]   wdata_c;

    assign pend_valid = (state != EMPTY);
    assign w_req      = bus.W_gpr_wen && (bus.W_rd_addr != '0);
    // Results for x0 complete the handshake but are never held.
    assign load       = bus.L_valid && !pend_valid && (bus.L_rd_addr != '0);

`ifdef GPR_WB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end
`else
    // STARVE_MAX has no effect without the starvation guard.
    logic [3:0] unused_starve_max;
    assign unused_starve_max = 4'(STARVE_MAX);
`endif

    always_comb begin
        state_nxt = state;
        wen_c     = 1'b0;
        stall_c   = 1'b0;
        waddr_c   = '0;
        wdata_c   = '0;
`ifdef GPR_WB_STARVE_GUARD_EN
        starve_cnt_nxt = starve_cnt;
`endif
        case (state)
            EMPTY: begin
                if (w_req) begin
                    wen_c   = 1'b1;
                    waddr_c = bus.W_rd_addr;
                    wdata_c = bus.W_rd;
                end
                if (load) begin
                    state_nxt = HELD;
`ifdef GPR_WB_STARVE_GUARD_EN
                    starve_cnt_nxt = '0;
`endif
                end
            end
            HELD: begin
                if (w_req) begin
                    wen_c   = 1'b1;
                    waddr_c = bus.W_rd_addr;
                    wdata_c = bus.W_rd;
                    // Younger W write to the same register makes the held value dead.
                    if (bus.W_rd_addr == pend_addr) begin
                        state_nxt = EMPTY;
                    end
`ifdef GPR_WB_STARVE_GUARD_EN
                    else begin
                        starve_cnt_nxt = starve_cnt + 4'd1;
                        if (starve_cnt_nxt == STARVE_LIM) begin
                            state_nxt = FORCE;
                        end
                    end
`endif
                end else begin
                    wen_c     = 1'b1;
                    waddr_c   = pend_addr;
                    wdata_c   = pend_data;
                    state_nxt = EMPTY;
                end
            end
            FORCE: begin
`ifdef GPR_WB_STARVE_GUARD_EN
                wen_c   = 1'b1;
                stall_c = 1'b1;
                waddr_c = pend_addr;
                wdata_c = pend_data;
`endif
                state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                pend_addr <= bus.L_rd_addr;
                pend_data <= bus.L_rd;
            end
        end
    end

    // Outputs are forced quiet while reset is asserted, without waiting for an edge.
    assign bus.gpr_wen      = reset && wen_c;
    assign bus.gpr_waddr    = waddr_c;
    assign bus.gpr_wdata    = wdata_c;
    assign bus.W_stall      = reset && stall_c;
    assign bus.L_ready      = reset && !pend_valid;
    assign bus.pend_valid   = pend_valid;
    assign bus.pend_rd_addr = pend_addr;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: expected register-file writes go through a scoreboard queue.
module tb_gpr_wb_arbiter;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic reset;
    int   total;
    int   passed;
    wr_t  exp_q[$];

    gpr_wb_arbiter_if bus ();

    gpr_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.W_gpr_wen = 1'b0;
        bus.W_rd_addr = '0;
        bus.W_rd      = '0;
        bus.L_valid   = 1'b0;
        bus.L_rd_addr = '0;
        bus.L_rd      = '0;
    endtask

    task automatic drive_w(input logic [4:0] a, input logic [31:0] d);
        bus.W_gpr_wen = 1'b1;
        bus.W_rd_addr = a;
        bus.W_rd      = d;
    endtask

    task automatic drive_l(input logic [4:0] a, input logic [31:0] d);
        bus.L_valid   = 1'b1;
        bus.L_rd_addr = a;
        bus.L_rd      = d;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        drive_w(5'd5, 32'h1);
        drive_l(5'd6, 32'h2);
        @(negedge clk);
        total++; if (bus.gpr_wen !== 1'b0) $display("FAIL rst_gpr_wen: got %b expected 0", bus.gpr_wen); else passed++;
        total++; if (bus.W_stall !== 1'b0) $display("FAIL rst_w_stall: got %b expected 0", bus.W_stall); else passed++;
        total++; if (bus.L_ready !== 1'b0) $display("FAIL rst_l_ready: got %b expected 0", bus.L_ready); else passed++;
        total++; if (bus.pend_valid !== 1'b0) $display("FAIL rst_pend_valid: got %b expected 0", bus.pend_valid); else passed++;
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.L_ready !== 1'b1) $display("FAIL rel_l_ready: got %b expected 1", bus.L_ready); else passed++;
        total++; if (bus.gpr_wen !== 1'b0) $display("FAIL rel_gpr_wen: got %b expected 0", bus.gpr_wen); else passed++;
    endtask

    task automatic test_pipeline_only();
        logic [4:0]  a;
        logic [31:0] d;
        @(posedge clk); #1;
        drive_w(5'd5, 32'hDEADBEEF);
        push(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        total++; if (bus.gpr_wen !== 1'b1) $display("FAIL pipe_wen: got %b expected 1", bus.gpr_wen); else passed++;
        total++; if (bus.gpr_waddr !== 5'd5) $display("FAIL pipe_waddr: got %0d expected 5", bus.gpr_waddr); else passed++;
        total++; if (bus.gpr_wdata !== 32'hDEADBEEF) $display("FAIL pipe_wdata: got %h expected deadbeef", bus.gpr_wdata); else passed++;
        total++; if (bus.W_stall !== 1'b0) $display("FAIL pipe_stall: got %b expected 0", bus.W_stall); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a = 5'($urandom_range(31, 1));
            d = $urandom();
            drive_w(a, d);
            push(a, d);
            @(negedge clk);
            total++; if (bus.gpr_waddr !== a) $display("FAIL pipe_rand_waddr: got %0d expected %0d", bus.gpr_waddr, a); else passed++;
        end
        @(posedge clk); #1;
        drive_w(5'd0, 32'h77);
        @(negedge clk);
        total++; if (bus.gpr_wen !== 1'b0) $display("FAIL pipe_x0_wen: got %b expected 0", bus.gpr_wen); else passed++;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_idle_port();
        @(posedge clk); #1;
        drive_l(5'd7, 32'h12);
        push(5'd7, 32'h12);
        @(negedge clk);
        total++; if (bus.L_ready !== 1'b1) $display("FAIL idle_l_ready_n: got %b expected 1", bus.L_ready); else passed++;
        total++; if (bus.gpr_wen !== 1'b0) $display("FAIL idle_wen_n: got %b expected 0", bus.gpr_wen); else passed++;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        total++; if (bus.gpr_wen !== 1'b1) $display("FAIL idle_wen_n1: got %b expected 1", bus.gpr_wen); else passed++;
        total++; if (bus.pend_valid !== 1'b1) $display("FAIL idle_pend_n1: got %b expected 1", bus.pend_valid); else passed++;
        total++; if (bus.pend_rd_addr !== 5'd7) $display("FAIL idle_pend_addr: got %0d expected 7", bus.pend_rd_addr); else passed++;
        total++; if (bus.L_ready !== 1'b0) $display("FAIL idle_l_ready_n1: got %b expected 0", bus.L_ready); else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.L_ready !== 1'b1) $display("FAIL idle_l_ready_n2: got %b expected 1", bus.L_ready); else passed++;
        total++; if (bus.pend_valid !== 1'b0) $display("FAIL idle_pend_n2: got %b expected 0", bus.pend_valid); else passed++;
        total++; if (exp_q.size() != 0) $display("FAIL idle_sb_drain: got %0d pending expected 0", exp_q.size()); else passed++;
    endtask

`ifdef GPR_WB_STARVE_GUARD_EN
    task automatic test_starvation();
        @(posedge clk); #1;
        drive_l(5'd9, 32'h99);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            drive_w(5'd3, 32'h300 + 32'(i));
            push(5'd3, 32'h300 + 32'(i));
            @(negedge clk);
            total++; if (bus.W_stall !== 1'b0) $display("FAIL starve_stall_early: got %b expected 0 at %0d", bus.W_stall, i); else passed++;
        end
        @(posedge clk); #1;
        drive_w(5'd3, 32'h304);
        push(5'd9, 32'h99);
        @(negedge clk);
        total++; if (bus.W_stall !== 1'b1) $display("FAIL starve_stall: got %b expected 1", bus.W_stall); else passed++;
        total++; if (bus.gpr_waddr !== 5'd9) $display("FAIL starve_force_addr: got %0d expected 9", bus.gpr_waddr); else passed++;
        @(posedge clk); #1;
        push(5'd3, 32'h304);
        @(negedge clk);
        total++; if (bus.W_stall !== 1'b0) $display("FAIL starve_resume_stall: got %b expected 0", bus.W_stall); else passed++;
        total++; if (bus.pend_valid !== 1'b0) $display("FAIL starve_pend: got %b expected 0", bus.pend_valid); else passed++;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        total++; if (exp_q.size() != 0) $display("FAIL starve_sb_drain: got %0d pending expected 0", exp_q.size()); else passed++;
    endtask
`else
    task automatic test_no_starve_guard();
        @(posedge clk); #1;
        drive_l(5'd9, 32'h99);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            drive_w(5'd3, 32'h300 + 32'(i));
            push(5'd3, 32'h300 + 32'(i));
            @(negedge clk);
            total++; if (bus.W_stall !== 1'b0) $display("FAIL noguard_stall: got %b expected 0 at %0d", bus.W_stall, i); else passed++;
            total++; if (bus.pend_valid !== 1'b1) $display("FAIL noguard_pend: got %b expected 1 at %0d", bus.pend_valid, i); else passed++;
        end
        @(posedge clk); #1;
        idle_inputs();
        push(5'd9, 32'h99);
        @(negedge clk);
        total++; if (bus.gpr_waddr !== 5'd9) $display("FAIL noguard_addr: got %0d expected 9", bus.gpr_waddr); else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (exp_q.size() != 0) $display("FAIL noguard_sb_drain: got %0d pending expected 0", exp_q.size()); else passed++;
    endtask
`endif

    task automatic test_waw_squash();
        @(posedge clk); #1;
        drive_l(5'd10, 32'h1010);
        @(posedge clk); #1;
        idle_inputs();
        drive_w(5'd10, 32'hAA);
        push(5'd10, 32'hAA);
        @(negedge clk);
        total++; if (bus.gpr_wdata !== 32'hAA) $display("FAIL waw_wdata: got %h expected aa", bus.gpr_wdata); else passed++;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        total++; if (bus.pend_valid !== 1'b0) $display("FAIL waw_pend: got %b expected 0", bus.pend_valid); else passed++;
        total++; if (bus.gpr_wen !== 1'b0) $display("FAIL waw_no_write: got %b expected 0", bus.gpr_wen); else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.gpr_wen !== 1'b0) $display("FAIL waw_no_late_write: got %b expected 0", bus.gpr_wen); else passed++;
        total++; if (exp_q.size() != 0) $display("FAIL waw_sb_drain: got %0d pending expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_x0();
        @(posedge clk); #1;
        drive_l(5'd0, 32'h55);
        @(negedge clk);
        total++; if (bus.L_ready !== 1'b1) $display("FAIL x0_l_ready: got %b expected 1", bus.L_ready); else passed++;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        total++; if (bus.pend_valid !== 1'b0) $display("FAIL x0_pend: got %b expected 0", bus.pend_valid); else passed++;
        total++; if (bus.gpr_wen !== 1'b0) $display("FAIL x0_l_wen: got %b expected 0", bus.gpr_wen); else passed++;
        @(posedge clk); #1;
        drive_l(5'd12, 32'hC0FFEE);
        @(posedge clk); #1;
        idle_inputs();
        drive_w(5'd0, 32'h77);
        push(5'd12, 32'hC0FFEE);
        @(negedge clk);
        total++; if (bus.gpr_waddr !== 5'd12) $display("FAIL x0_held_granted: got %0d expected 12", bus.gpr_waddr); else passed++;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        total++; if (bus.pend_valid !== 1'b0) $display("FAIL x0_held_cleared: got %b expected 0", bus.pend_valid); else passed++;
        total++; if (exp_q.size() != 0) $display("FAIL x0_sb_drain: got %0d pending expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  la [4];
        logic [31:0] ld [4];
        logic [4:0]  wa;
        logic [31:0] wd;
        for (int j = 0; j < 4; j++) begin
            la[j] = 5'($urandom_range(31, 1));
            ld[j] = $urandom();
        end
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            wa = 5'($urandom_range(31, 1));
            wd = $urandom();
            drive_w(wa, wd);
            drive_l(la[j], ld[j]);
            push(wa, wd);
            push(la[j], ld[j]);
            @(negedge clk);
            total++; if (bus.L_ready !== 1'b1) $display("FAIL b2b_accept_ready: got %b expected 1 at %0d", bus.L_ready, j); else passed++;
            @(posedge clk); #1;
            idle_inputs();
            if (j < 2) drive_l(la[j+1], ld[j+1]);
            @(negedge clk);
            total++; if (bus.L_ready !== 1'b0) $display("FAIL b2b_hold_ready: got %b expected 0 at %0d", bus.L_ready, j); else passed++;
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        total++; if (exp_q.size() != 0) $display("FAIL b2b_sb_drain: got %0d pending expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        drive_l(5'd9, 32'h4949);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            drive_w(5'd3, 32'h400 + 32'(i));
            push(5'd3, 32'h400 + 32'(i));
        end
        @(posedge clk); #1;
        drive_w(5'd3, 32'h404);
`ifdef GPR_WB_STARVE_GUARD_EN
        push(5'd9, 32'h4949);
`else
        push(5'd3, 32'h404);
`endif
        @(negedge clk);
`ifdef GPR_WB_STARVE_GUARD_EN
        total++; if (bus.W_stall !== 1'b1) $display("FAIL mid_force_stall: got %b expected 1", bus.W_stall); else passed++;
`endif
        total++; if (bus.gpr_wen !== 1'b1) $display("FAIL mid_pre_wen: got %b expected 1", bus.gpr_wen); else passed++;
        #1;
        reset = 1'b0;
        #1;
        total++; if (bus.W_stall !== 1'b0) $display("FAIL mid_rst_stall: got %b expected 0", bus.W_stall); else passed++;
        total++; if (bus.gpr_wen !== 1'b0) $display("FAIL mid_rst_wen: got %b expected 0", bus.gpr_wen); else passed++;
        total++; if (bus.pend_valid !== 1'b0) $display("FAIL mid_rst_pend: got %b expected 0", bus.pend_valid); else passed++;
        idle_inputs();
        @(posedge clk); #3;
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.pend_valid !== 1'b0) $display("FAIL mid_rel_pend: got %b expected 0", bus.pend_valid); else passed++;
        total++; if (bus.L_ready !== 1'b1) $display("FAIL mid_rel_l_ready: got %b expected 1", bus.L_ready); else passed++;
        total++; if (bus.gpr_wen !== 1'b0) $display("FAIL mid_rel_wen: got %b expected 0", bus.gpr_wen); else passed++;
        total++; if (exp_q.size() != 0) $display("FAIL mid_sb_drain: got %0d pending expected 0", exp_q.size()); else passed++;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b0;
        idle_inputs();
        fork
            forever begin
                @(negedge clk);
                if (reset === 1'b1 && bus.gpr_wen === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_unexpected_write: got addr %0d data %h expected no write",
                                 bus.gpr_waddr, bus.gpr_wdata);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        if ({bus.gpr_waddr, bus.gpr_wdata} !== {e.addr, e.data})
                            $display("FAIL sb_write: got addr %0d data %h expected addr %0d data %h",
                                     bus.gpr_waddr, bus.gpr_wdata, e.addr, e.data);
                        else
                            passed++;
                    end
                end
            end
        join_none
        test_reset();
        test_pipeline_only();
        test_idle_port();
`ifdef GPR_WB_STARVE_GUARD_EN
        test_starvation();
`else
        test_no_starve_guard();
`endif
        test_waw_squash();
        test_x0();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
